// File: rtl/pifo_io_arbiter_if.sv
// rtl/pifo_io_arbiter_if.sv - host push/pop and PIFO-side signal bundle for pifo_io_arbiter
// Purpose: groups every non-clock/reset signal of pifo_io_arbiter.
// Ports (as seen from the arbiter, modport slave):
//   host push : i_push_valid/o_push_ready per channel, i_push_tree_id, i_push_data
//   host pop  : i_pop_valid/o_pop_ready, i_pop_tree_id, o_pop_valid/o_pop_tree_id/o_pop_data,
//               o_pop_timeout, o_resp_err, o_tree_empty
//   PIFO push : pifo_push_o, pifo_push_tree_id_o, pifo_push_data_o, pifo_full_i
//   PIFO pop  : pifo_pop_o, pifo_pop_tree_id_o, pifo_pop_valid_i, pifo_pop_tree_id_i, pifo_pop_data_i
// Modport master is the mirror image used by whatever drives the arbiter inputs.
interface pifo_io_arbiter_if #(
  parameter int PTW      = 16,
  parameter int MTW      = 32,
  parameter int PLW      = 12,
  parameter int TREE_NUM = 4,
  parameter int NCH      = 4
);
  localparam int DW  = MTW + PTW + PLW;
  localparam int TNB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;

  logic [NCH-1:0]      i_push_valid;
  logic [NCH-1:0]      o_push_ready;
  logic [NCH*TNB-1:0]  i_push_tree_id;
  logic [NCH*DW-1:0]   i_push_data;
  logic                i_pop_valid;
  logic [TNB-1:0]      i_pop_tree_id;
  logic                o_pop_ready;
  logic                o_pop_valid;
  logic [TNB-1:0]      o_pop_tree_id;
  logic [DW-1:0]       o_pop_data;
  logic                o_pop_timeout;
  logic                o_resp_err;
  logic [TREE_NUM-1:0] o_tree_empty;
  logic                pifo_push_o;
  logic [TNB-1:0]      pifo_push_tree_id_o;
  logic [DW-1:0]       pifo_push_data_o;
  logic                pifo_full_i;
  logic                pifo_pop_o;
  logic [TNB-1:0]      pifo_pop_tree_id_o;
  logic                pifo_pop_valid_i;
  logic [TNB-1:0]      pifo_pop_tree_id_i;
  logic [DW-1:0]       pifo_pop_data_i;

  modport slave (
    input  i_push_valid, i_push_tree_id, i_push_data, i_pop_valid, i_pop_tree_id,
           pifo_full_i, pifo_pop_valid_i, pifo_pop_tree_id_i, pifo_pop_data_i,
    output o_push_ready, o_pop_ready, o_pop_valid, o_pop_tree_id, o_pop_data, o_pop_timeout,
           o_resp_err, o_tree_empty, pifo_push_o, pifo_push_tree_id_o, pifo_push_data_o,
           pifo_pop_o, pifo_pop_tree_id_o
  );

  modport master (
    output i_push_valid, i_push_tree_id, i_push_data, i_pop_valid, i_pop_tree_id,
           pifo_full_i, pifo_pop_valid_i, pifo_pop_tree_id_i, pifo_pop_data_i,
    input  o_push_ready, o_pop_ready, o_pop_valid, o_pop_tree_id, o_pop_data, o_pop_timeout,
           o_resp_err, o_tree_empty, pifo_push_o, pifo_push_tree_id_o, pifo_push_data_o,
           pifo_pop_o, pifo_pop_tree_id_o
  );
endinterface

// File: rtl/pifo_io_arbiter.sv
// rtl/pifo_io_arbiter.sv - multi-channel ingress FIFOs, RR push arbiter and pop FSM for the PIFO
// Purpose: buffers NCH push channels, round-robins them onto the single PIFO push port, tracks
//   per-tree occupancy and runs a one-outstanding pop request with response timeout.
// Ports: i_clk, i_arst_n (async active-low), io (pifo_io_arbiter_if.slave, all host/PIFO signals).
module pifo_io_arbiter #(
  parameter int PTW      = 16,
  parameter int MTW      = 32,
  parameter int PLW      = 12,
  parameter int TREE_NUM = 4,
  parameter int NCH      = 4,
  parameter int IQ_DEPTH = 4,
  parameter int CTW      = 10,
  parameter int TMO      = 64
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  pifo_io_arbiter_if.slave io
);
  localparam int DW  = MTW + PTW + PLW;
  localparam int TNB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
  localparam int CHB = $clog2(NCH);
  localparam int QAW = $clog2(IQ_DEPTH);
  localparam int QCW = QAW + 1;
  localparam int TW  = $clog2(TMO);
  localparam logic [CTW-1:0] OCC_MAX = '1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  logic [TNB-1:0] iq_tree_q [NCH][IQ_DEPTH];
  logic [DW-1:0]  iq_data_q [NCH][IQ_DEPTH];
  logic [QAW-1:0] wr_ptr_q  [NCH];
  logic [QAW-1:0] rd_ptr_q  [NCH];
  logic [QCW-1:0] cnt_q     [NCH];
  logic [CTW-1:0] occ_q     [TREE_NUM];
  logic [CHB-1:0] rr_q;

  logic           push_q;
  logic [TNB-1:0] push_tree_q;
  logic [DW-1:0]  push_data_q;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q;
  logic           pifo_pop_q;
  logic [TNB-1:0] pifo_pop_tree_q;
  logic           pop_valid_q, pop_timeout_q, resp_err_q;
  logic [TNB-1:0] pop_tree_q;
  logic [DW-1:0]  pop_data_q;

  logic [NCH-1:0]      ready, wr_en, rd_en, eligible;
  logic                grant_vld;
  logic [CHB-1:0]      grant_idx;
  logic [TNB-1:0]      grant_tree;
  logic [TREE_NUM-1:0] occ_inc, occ_dec, empty;
  logic                pop_ready, pop_accept, resp_take, tmo_hit, dec_underflow;

  // Ready comes from the registered count only, so a full FIFO never accepts even while draining.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      ready[c]    = (cnt_q[c] != QCW'(IQ_DEPTH));
      wr_en[c]    = io.i_push_valid[c] && ready[c];
      eligible[c] = (cnt_q[c] != '0) && (occ_q[iq_tree_q[c][rd_ptr_q[c]]] != OCC_MAX);
    end
  end

  // First eligible channel at or after the RR pointer, with explicit wrap for non-power-of-2 NCH.
  always_comb begin
    logic [CHB:0] s;
    grant_vld = 1'b0;
    grant_idx = '0;
    s         = '0;
    for (int k = 0; k < NCH; k++) begin
      s = {1'b0, rr_q} + (CHB+1)'(k);
      if (s >= (CHB+1)'(NCH)) s = s - (CHB+1)'(NCH);
      if (!grant_vld && eligible[s[CHB-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = s[CHB-1:0];
      end
    end
    if (io.pifo_full_i) grant_vld = 1'b0;
    grant_tree = iq_tree_q[grant_idx][rd_ptr_q[grant_idx]];
    for (int c = 0; c < NCH; c++) rd_en[c] = grant_vld && (grant_idx == CHB'(c));
  end

  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (wr_en[c]) begin
        iq_tree_q[c][wr_ptr_q[c]] <= io.i_push_tree_id[c*TNB +: TNB];
        iq_data_q[c][wr_ptr_q[c]] <= io.i_push_data[c*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      rr_q        <= '0;
      push_q      <= 1'b0;
      push_tree_q <= '0;
      push_data_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_en[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (rd_en[c]) rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        cnt_q[c] <= cnt_q[c] + QCW'(wr_en[c]) - QCW'(rd_en[c]);
      end
      push_q <= grant_vld;
      if (grant_vld) begin
        push_tree_q <= grant_tree;
        push_data_q <= iq_data_q[grant_idx][rd_ptr_q[grant_idx]];
        rr_q        <= (grant_idx == CHB'(NCH-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Occupancy: a push and a pop response on the same tree cancel; a decrement at zero is dropped.
  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) begin
      occ_inc[t] = grant_vld && (grant_tree == TNB'(t));
      occ_dec[t] = resp_take && (io.pifo_pop_tree_id_i == TNB'(t));
      empty[t]   = (occ_q[t] == '0);
    end
    dec_underflow = resp_take && (occ_q[io.pifo_pop_tree_id_i] == '0) &&
                    !(grant_vld && (grant_tree == io.pifo_pop_tree_id_i));
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int t = 0; t < TREE_NUM; t++) occ_q[t] <= '0;
    end else begin
      for (int t = 0; t < TREE_NUM; t++) begin
        if (occ_inc[t] && !occ_dec[t]) occ_q[t] <= occ_q[t] + 1'b1;
        else if (occ_dec[t] && !occ_inc[t] && (occ_q[t] != '0)) occ_q[t] <= occ_q[t] - 1'b1;
      end
    end
  end

  // Pop FSM: one request outstanding; responses seen while IDLE are dropped.
  always_comb begin
    state_d    = state_q;
    pop_ready  = 1'b0;
    pop_accept = 1'b0;
    resp_take  = 1'b0;
    tmo_hit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop_ready = (occ_q[io.i_pop_tree_id] != '0);
        if (io.i_pop_valid && pop_ready) begin
          pop_accept = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (io.pifo_pop_valid_i) begin
          resp_take = 1'b1;
          state_d   = S_IDLE;
        end else if (timer_q == TW'(TMO-1)) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      pifo_pop_q      <= 1'b0;
      pifo_pop_tree_q <= '0;
      pop_valid_q     <= 1'b0;
      pop_tree_q      <= '0;
      pop_data_q      <= '0;
      pop_timeout_q   <= 1'b0;
      resp_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pifo_pop_q    <= pop_accept;
      pop_valid_q   <= resp_take;
      pop_timeout_q <= tmo_hit;
      if (pop_accept) begin
        pifo_pop_tree_q <= io.i_pop_tree_id;
        timer_q         <= '0;
      end else if (state_q == S_WAIT) begin
        timer_q <= timer_q + 1'b1;
      end
      if (resp_take) begin
        pop_tree_q <= io.pifo_pop_tree_id_i;
        pop_data_q <= io.pifo_pop_data_i;
      end
      // pifo_pop_tree_q still holds the request id while waiting for its response.
      if ((resp_take && (io.pifo_pop_tree_id_i != pifo_pop_tree_q)) || dec_underflow)
        resp_err_q <= 1'b1;
    end
  end

  assign io.o_push_ready        = ready;
  assign io.o_tree_empty        = empty;
  assign io.o_pop_ready         = pop_ready;
  assign io.o_pop_valid         = pop_valid_q;
  assign io.o_pop_tree_id       = pop_tree_q;
  assign io.o_pop_data          = pop_data_q;
  assign io.o_pop_timeout       = pop_timeout_q;
  assign io.o_resp_err          = resp_err_q;
  assign io.pifo_push_o         = push_q;
  assign io.pifo_push_tree_id_o = push_tree_q;
  assign io.pifo_push_data_o    = push_data_q;
  assign io.pifo_pop_o          = pifo_pop_q;
  assign io.pifo_pop_tree_id_o  = pifo_pop_tree_q;
endmodule

// File: tb/tb_pifo_io_arbiter.sv
// tb/tb_pifo_io_arbiter.sv - self-checking bench for pifo_io_arbiter
module tb_pifo_io_arbiter;
  localparam int DW  = 60;
  localparam int TNB = 2;
  localparam int NCH = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pifo_io_arbiter_if bus ();
  pifo_io_arbiter dut (.i_clk(clk), .i_arst_n(rst_n), .io(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic pv; int pch; logic [1:0] ptree; logic [7:0] pdata;
    logic popv; logic [1:0] popt;
    logic rv; logic [1:0] rt; logic [7:0] rd;
    logic e_push; logic [1:0] e_ptree; logic [7:0] e_pdata;
    logic e_pifo_pop; logic [1:0] e_ppt;
    logic e_pop_ready; logic e_pop_valid; logic [7:0] e_pop_data; logic [3:0] e_empty;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_push_valid       = '0;
    bus.i_push_tree_id     = '0;
    bus.i_push_data        = '0;
    bus.i_pop_valid        = 1'b0;
    bus.i_pop_tree_id      = '0;
    bus.pifo_full_i        = 1'b0;
    bus.pifo_pop_valid_i   = 1'b0;
    bus.pifo_pop_tree_id_i = '0;
    bus.pifo_pop_data_i    = '0;
  endtask

  task automatic set_push(input int c, input logic [1:0] tree, input logic [7:0] d);
    bus.i_push_valid[c]            = 1'b1;
    bus.i_push_tree_id[c*TNB +: TNB] = tree;
    bus.i_push_data[c*DW +: DW]    = DW'(d);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_push_ready"}, 64'(bus.o_push_ready), 64'hF);
    chk({tag, "_tree_empty"}, 64'(bus.o_tree_empty), 64'hF);
    chk({tag, "_pifo_push"}, 64'(bus.pifo_push_o), 64'h0);
    chk({tag, "_pifo_push_data"}, 64'(bus.pifo_push_data_o), 64'h0);
    chk({tag, "_pifo_pop"}, 64'(bus.pifo_pop_o), 64'h0);
    chk({tag, "_pop_valid"}, 64'(bus.o_pop_valid), 64'h0);
    chk({tag, "_pop_data"}, 64'(bus.o_pop_data), 64'h0);
    chk({tag, "_pop_timeout"}, 64'(bus.o_pop_timeout), 64'h0);
    chk({tag, "_resp_err"}, 64'(bus.o_resp_err), 64'h0);
    chk({tag, "_pop_ready"}, 64'(bus.o_pop_ready), 64'h0);
  endtask

  initial begin
    int n;
    int tcount;
    int pcount;
    int first;

    // pv pch ptree pdata | popv popt | rv rt rd | e_push e_ptree e_pdata | e_pifo_pop e_ppt | e_pop_ready e_pop_valid e_pop_data e_empty
    tbl[0] = '{1'b1, 0, 2'd1, 8'hA5, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'hF};
    tbl[1] = '{1'b0, 0, 2'd0, 8'h00, 1'b0, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'hF};
    tbl[2] = '{1'b1, 2, 2'd2, 8'h33, 1'b0, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'hD};
    tbl[3] = '{1'b0, 0, 2'd0, 8'h00, 1'b0, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'hD};
    tbl[4] = '{1'b0, 0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'h9};
    tbl[5] = '{1'b0, 0, 2'd0, 8'h00, 1'b0, 2'd2, 1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 4'h9};
    tbl[6] = '{1'b0, 0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 8'h33, 4'hD};
    tbl[7] = '{1'b0, 0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1, 2'd1, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'hD};
    tbl[8] = '{1'b0, 0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'hD};

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    next_cyc();
    rst_n = 1'b1;

    // Single push latency, pop gating on empty tree, pop round trip, response in IDLE ignored.
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      if (tbl[i].pv) set_push(tbl[i].pch, tbl[i].ptree, tbl[i].pdata);
      bus.i_pop_valid        = tbl[i].popv;
      bus.i_pop_tree_id      = tbl[i].popt;
      bus.pifo_pop_valid_i   = tbl[i].rv;
      bus.pifo_pop_tree_id_i = tbl[i].rt;
      bus.pifo_pop_data_i    = DW'(tbl[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d_pifo_push", i), 64'(bus.pifo_push_o), 64'(tbl[i].e_push));
      if (tbl[i].e_push) begin
        chk($sformatf("v%0d_push_tree", i), 64'(bus.pifo_push_tree_id_o), 64'(tbl[i].e_ptree));
        chk($sformatf("v%0d_push_data", i), 64'(bus.pifo_push_data_o), 64'(tbl[i].e_pdata));
      end
      chk($sformatf("v%0d_pifo_pop", i), 64'(bus.pifo_pop_o), 64'(tbl[i].e_pifo_pop));
      if (tbl[i].e_pifo_pop)
        chk($sformatf("v%0d_pifo_pop_tree", i), 64'(bus.pifo_pop_tree_id_o), 64'(tbl[i].e_ppt));
      chk($sformatf("v%0d_pop_ready", i), 64'(bus.o_pop_ready), 64'(tbl[i].e_pop_ready));
      chk($sformatf("v%0d_pop_valid", i), 64'(bus.o_pop_valid), 64'(tbl[i].e_pop_valid));
      if (tbl[i].e_pop_valid)
        chk($sformatf("v%0d_pop_data", i), 64'(bus.o_pop_data), 64'(tbl[i].e_pop_data));
      chk($sformatf("v%0d_tree_empty", i), 64'(bus.o_tree_empty), 64'(tbl[i].e_empty));
      next_cyc();
    end

    // Round robin across four loaded channels with a 3-cycle full stall.
    rst_n = 1'b0;
    idle_inputs();
    next_cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      bus.pifo_full_i = 1'b1;
      for (int c = 0; c < NCH; c++) set_push(c, 2'(c), 8'(c*16 + k));
      next_cyc();
    end
    idle_inputs();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      bus.pifo_full_i = (i >= 3 && i < 6);
      @(negedge clk);
      if (i >= 4 && i <= 6) chk($sformatf("rr_stall_c%0d", i), 64'(bus.pifo_push_o), 64'h0);
      if (bus.pifo_push_o) begin
        if (n < 8) begin
          chk($sformatf("rr_data_%0d", n), 64'(bus.pifo_push_data_o), 64'((n % 4) * 16 + n / 4));
          chk($sformatf("rr_tree_%0d", n), 64'(bus.pifo_push_tree_id_o), 64'(n % 4));
        end
        n++;
      end
      next_cyc();
    end
    chk("rr_push_count", 64'(n), 64'd8);

    // Ingress FIFO fill on channel 1: fifth push refused.
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      bus.pifo_full_i = 1'b1;
      set_push(1, 2'd1, 8'(8'h50 + k));
      @(negedge clk);
      chk($sformatf("fill_ready_%0d", k), 64'(bus.o_push_ready[1]), 64'(k < 4));
      next_cyc();
    end
    idle_inputs();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pifo_push_o) begin
        if (n < 4) chk($sformatf("fill_data_%0d", n), 64'(bus.pifo_push_data_o), 64'(8'h50 + n));
        n++;
      end
      next_cyc();
    end
    chk("fill_push_count", 64'(n), 64'd4);

    // Pop timeout on tree 0 (occupancy 2).
    idle_inputs();
    bus.i_pop_valid   = 1'b1;
    bus.i_pop_tree_id = 2'd0;
    @(negedge clk);
    chk("tmo_pop_ready", 64'(bus.o_pop_ready), 64'h1);
    next_cyc();
    idle_inputs();
    tcount = 0;
    pcount = 0;
    first  = -1;
    for (int i = 1; i <= TMO + 8; i++) begin
      @(negedge clk);
      if (bus.pifo_pop_o) begin
        pcount++;
        chk("tmo_pifo_pop_tree", 64'(bus.pifo_pop_tree_id_o), 64'h0);
      end
      if (bus.o_pop_timeout) begin
        tcount++;
        if (first < 0) first = i;
      end
      next_cyc();
    end
    chk("tmo_pulse_count", 64'(tcount), 64'd1);
    chk("tmo_pulse_cycle", 64'(first), 64'(TMO + 1));
    chk("tmo_pifo_pop_count", 64'(pcount), 64'd1);
    @(negedge clk);
    chk("tmo_occ_kept", 64'(bus.o_tree_empty), 64'h0);
    chk("tmo_idle_ready", 64'(bus.o_pop_ready), 64'h1);
    next_cyc();

    // Response tree id mismatch: data forwarded, sticky error.
    bus.i_pop_valid   = 1'b1;
    bus.i_pop_tree_id = 2'd0;
    next_cyc();
    idle_inputs();
    bus.pifo_pop_valid_i   = 1'b1;
    bus.pifo_pop_tree_id_i = 2'd1;
    bus.pifo_pop_data_i    = DW'(8'h99);
    @(negedge clk);
    chk("mis_pifo_pop", 64'(bus.pifo_pop_o), 64'h1);
    chk("mis_err_before", 64'(bus.o_resp_err), 64'h0);
    next_cyc();
    idle_inputs();
    @(negedge clk);
    chk("mis_pop_valid", 64'(bus.o_pop_valid), 64'h1);
    chk("mis_pop_tree", 64'(bus.o_pop_tree_id), 64'h1);
    chk("mis_pop_data", 64'(bus.o_pop_data), 64'h99);
    chk("mis_resp_err", 64'(bus.o_resp_err), 64'h1);
    next_cyc();
    @(negedge clk);
    chk("mis_err_sticky", 64'(bus.o_resp_err), 64'h1);
    next_cyc();

    // Reset while FIFOs hold entries and the FSM waits.
    idle_inputs();
    bus.pifo_full_i = 1'b1;
    set_push(0, 2'd2, 8'h11);
    set_push(3, 2'd3, 8'h22);
    bus.i_pop_valid   = 1'b1;
    bus.i_pop_tree_id = 2'd1;
    next_cyc();
    idle_inputs();
    bus.pifo_full_i = 1'b1;
    @(negedge clk);
    chk("rst_pre_wait", 64'(bus.pifo_pop_o), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    next_cyc();
    rst_n = 1'b1;
    bus.pifo_full_i = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pifo_push_o) n++;
      next_cyc();
    end
    chk("rst_no_stale_push", 64'(n), 64'h0);
    @(negedge clk);
    chk("rst_tree_empty", 64'(bus.o_tree_empty), 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
